spi_flash_reader: RTL



---
 rtl/spi_flash_reader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_reader.sv
// Single-word SPI mode-0 flash reader: command 0x03 + 24-bit address, 32 data bits, behind a ready/valid pair.
// Define FLASH_WAKEUP_EN to send a 0xAB release-from-deep-power-down frame after reset.
module spi_flash_reader #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned WAKE_GAP = 32
) (
   input  logic        clock,
   input  logic        resetb,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic        flash_csb,
   output logic        flash_clk,
   output logic        flash_io0,
   input  logic        flash_io1
);

   localparam int unsigned SLOT_LEN = 2 * CLK_DIV;
   localparam int unsigned CNT_MAX  = (SLOT_LEN > WAKE_GAP) ? SLOT_LEN : WAKE_GAP;
   localparam int unsigned CW       = $clog2(CNT_MAX + 1);
   localparam logic [7:0]  CMD_READ = 8'h03;
`ifdef FLASH_WAKEUP_EN
   localparam logic [7:0]  CMD_WAKE = 8'hAB;
`endif

   typedef enum logic [2:0] {
      ST_RESET,
      ST_IDLE,
      ST_SHIFT,
      ST_DONE,
      ST_GAP
`ifdef FLASH_WAKEUP_EN
      , ST_WAKE_CMD
      , ST_WAKE_GAP
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    slot_q, slot_d;
   logic [31:0]   shreg_q, shreg_d;
   logic [31:0]   rx_q, rx_d;
   logic          csb_d, sclk_d, io0_d;
   logic          ready_d, rsp_valid_d, busy_d;
   logic [31:0]   rsp_data_d;
   logic          last_slot;

   // The wakeup frame is 8 slots long, a read frame 64.
   always_comb begin
      last_slot = (slot_q == 6'd63);
`ifdef FLASH_WAKEUP_EN
      if (state_q == ST_WAKE_CMD) last_slot = (slot_q == 6'd7);
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      slot_d      = slot_q;
      shreg_d     = shreg_q;
      rx_d        = rx_q;
      csb_d       = flash_csb;
      sclk_d      = flash_clk;
      io0_d       = flash_io0;
      ready_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data;
      busy_d      = busy;

      case (state_q)
         ST_RESET: begin
`ifdef FLASH_WAKEUP_EN
            state_d = ST_WAKE_CMD;
            shreg_d = {CMD_WAKE, 24'h0};
            cnt_d   = '0;
            slot_d  = '0;
            csb_d   = 1'b0;
            sclk_d  = 1'b0;
            io0_d   = CMD_WAKE[7];
            busy_d  = 1'b1;
`else
            state_d = ST_IDLE;
            ready_d = 1'b1;
`endif
         end

         ST_IDLE: begin
            ready_d = 1'b1;
            csb_d   = 1'b1;
            if (req_valid && req_ready) begin
               state_d = ST_SHIFT;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               csb_d   = 1'b0;
               sclk_d  = 1'b0;
               shreg_d = {CMD_READ, req_addr};
               io0_d   = CMD_READ[7];
               cnt_d   = '0;
               slot_d  = '0;
            end
         end

`ifdef FLASH_WAKEUP_EN
         ST_WAKE_CMD,
`endif
         ST_SHIFT: begin
            cnt_d = cnt_q + CW'(1);
            // Rising edge mid-slot samples MISO; falling edge at slot end advances MOSI.
            if (cnt_q == CW'(CLK_DIV - 1)) begin
               sclk_d = 1'b1;
               rx_d   = {rx_q[30:0], flash_io1};
            end
            if (cnt_q == CW'(SLOT_LEN - 1)) begin
               cnt_d = '0;
               if (last_slot) begin
                  csb_d  = 1'b1;
                  sclk_d = 1'b0;
                  io0_d  = 1'b0;
`ifdef FLASH_WAKEUP_EN
                  if (state_q == ST_WAKE_CMD) begin
                     state_d = ST_WAKE_GAP;
                  end else
`endif
                  begin
                     state_d     = ST_DONE;
                     rsp_valid_d = 1'b1;
                     rsp_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                  end
               end else begin
                  slot_d  = slot_q + 6'd1;
                  sclk_d  = 1'b0;
                  shreg_d = {shreg_q[30:0], 1'b0};
                  io0_d   = shreg_q[30];
               end
            end
         end

         ST_DONE: begin
            state_d = ST_GAP;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end

         // Keeps chip select high for 2*CLK_DIV cycles before the next frame can start.
         ST_GAP: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(SLOT_LEN - 2)) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               cnt_d   = '0;
            end
         end

`ifdef FLASH_WAKEUP_EN
         ST_WAKE_GAP: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WAKE_GAP - 1)) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end
         end
`endif

         default: state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetb) begin
         state_q   <= ST_RESET;
         cnt_q     <= '0;
         slot_q    <= '0;
         shreg_q   <= '0;
         rx_q      <= '0;
         flash_csb <= 1'b1;
         flash_clk <= 1'b0;
         flash_io0 <= 1'b0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         slot_q    <= slot_d;
         shreg_q   <= shreg_d;
         rx_q      <= rx_d;
         flash_csb <= csb_d;
         flash_clk <= sclk_d;
         flash_io0 <= io0_d;
         req_ready <= ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         busy      <= busy_d;
      end
   end

endmodule
